vram_arb: RTL and testbench
===========================

Name: vram_arb

Overview:
- Arbitrates the PPU's single-port 8 KiB VRAM among three requesters:
  - the PPU pixel/tile fetcher (read-only, top priority);
  - the CPU bus (read/write);
  - a built-in clear sequencer that fills all of VRAM with one byte value.
- Sits between the CPU address decoder, ppu_m's fetcher and the VRAM macro.
- Drives the VRAM address/write/data lines that ppu_m currently takes as vram_addr_in / vram_write_in / vram_d_wr.

Parameters:
- AW, 13, VRAM address width (8 KiB).
- DW, 8, VRAM data width.

Ports:
- clk  in  1  system clock, all logic on posedge
- rst  in  1  synchronous, active-high reset
- ppu_mode  in  2  0 HBlank, 1 VBlank, 2 OAM scan, 3 pixel transfer
- ppu_req  in  1  PPU read request, single-cycle strobe
- ppu_addr  in  AW  PPU read address
- ppu_rd_valid  out  1  PPU read data valid
- ppu_rd_data  out  DW  PPU read data
- cpu_req  in  1  CPU request; held high until cpu_ack
- cpu_we  in  1  1 = write, 0 = read (held with cpu_req)
- cpu_addr  in  AW  CPU address (held with cpu_req)
- cpu_wdata  in  DW  CPU write data (held with cpu_req)
- cpu_ack  out  1  one-cycle completion pulse
- cpu_rdata  out  DW  CPU read data, valid with cpu_ack
- clr_start  in  1  start clear sequence (pulse)
- clr_value  in  DW  fill byte, sampled on accepted clr_start
- clr_busy  out  1  clear in progress
- clr_done  out  1  one-cycle pulse after final clear write
- vram_addr  out  AW  VRAM address
- vram_write  out  1  VRAM write enable
- vram_d_wr  out  DW  VRAM write data
- vram_d_rd  in  DW  VRAM read data; synchronous, valid the cycle after address

Behaviour:
- Reset values: ppu_rd_valid=0, cpu_ack=0, cpu_rdata=0, clr_busy=0, clr_done=0, vram_write=0, vram_addr=0, vram_d_wr=0, FSM=IDLE.
- Reset mid-clear or mid-CPU access aborts with no further VRAM writes and no ack.
- VRAM outputs are combinational muxes of the cycle's grant. With no grant: vram_write=0, address and data hold their last value.
- Grant priority, every cycle:
  1. PPU, whenever ppu_req=1.
  2. CLEAR step, when clr_busy.
  3. CPU.
- PPU read granted in cycle N → ppu_rd_valid=1, ppu_rd_data=vram_d_rd in N+1. Never stalled.
- FSM states:
  - IDLE: CPU or clear eligible.
  - CPU_ACK: CPU granted in N; cpu_ack=1 in N+1, with cpu_rdata=vram_d_rd for reads. Returns to IDLE.
  - CLEAR: walks the address pointer.
- CPU is not re-sampled during CPU_ACK. Next CPU grant is at earliest N+2, i.e. max one CPU access per 2 cycles.
- A CPU request that loses to ppu_req waits. It is granted in the first cycle without a PPU request, subject to the mode-3 rule under the optional feature.
- Clear sequence:
  - clr_start accepted only in IDLE with no CPU access pending ack. Otherwise ignored.
  - On accept: ptr=0, value latched, clr_busy=1 from the next cycle.
  - Each cycle without ppu_req: write value to ptr, ptr+1.
  - After the write to 13'h1FFF: clr_busy=0 and clr_done=1 in the following cycle. Back to IDLE; no wrap.
  - PPU reads preempt a step; the step retries at the same ptr.
  - CPU requests during CLEAR stall (no ack) until clear ends.
- Uncontested clear takes exactly 8192 write cycles.
- clr_start while busy: ignored. cpu_req and clr_start simultaneous in IDLE: clear wins and CPU stalls.

Optional Feature:
- Macro: VRAM_MODE3_LOCK_EN.
- Defined: while ppu_mode==3, CPU accesses are not granted to VRAM. They still complete in IDLE: cpu_ack pulses the next cycle.
  - Reads return cpu_rdata=8'hFF.
  - Writes are dropped (vram_write stays 0).
  - Clear is unaffected.
- Undefined: ppu_mode is ignored. CPU loses only cycle-by-cycle to ppu_req.

Test Plan:
1. Reset → all outputs 0. Then CPU write 0x1234←0xA5, CPU read 0x1234 → cpu_ack 1 cycle after each grant, cpu_rdata=0xA5.
2. ppu_req at 0x0010 in the same cycle as a held CPU read of 0x0020 → PPU granted first, ppu_rd_valid next cycle; CPU ack one cycle later.
3. clr_start, clr_value=0x00, no other traffic → clr_busy for 8192 cycles, clr_done once. Read back 0x0000, 0x1000, 0x1FFF → 0x00.
4. Clear with ppu_req every 4th cycle → completion at 8192 + number of PPU cycles. No address skipped; spot-check 0x0003 and 0x1FFC = fill value.
5. VRAM_MODE3_LOCK_EN, ppu_mode=3:
   - CPU write 0x0100←0x5A then read → ack, cpu_rdata=0xFF.
   - After ppu_mode=0, read 0x0100 → prior contents, not 0x5A.
6. rst asserted at ptr≈0x0800 mid-clear → clr_busy=0 next cycle, no clr_done, no further writes. Re-issued clr_start restarts at 0x0000.

Source files
------------

// File: rtl/vram_arb.sv
// ---------------------------------------------------------------------------
// vram_arb -- arbiter for the PPU's single-port 8 KiB VRAM.
//
// The arbiter has three requesters, in fixed priority order:
//   1. PPU fetcher   : read-only single-cycle strobes, never stalled.
//   2. Clear engine  : fills every VRAM byte with one value, one byte per
//                      cycle that the PPU leaves free.
//   3. CPU bus       : read/write. The request is held until cpu_ack, and
//                      at most one access completes every two cycles.
//
// Ports
//   clk, rst                  system clock; synchronous active-high reset
//   ppu_mode                  0 HBlank, 1 VBlank, 2 OAM scan, 3 pixel xfer
//   ppu_req/ppu_addr          PPU read strobe and address
//   ppu_rd_valid/ppu_rd_data  PPU read return, one cycle after grant
//   cpu_req/we/addr/wdata     CPU request, held until cpu_ack
//   cpu_ack/cpu_rdata         one-cycle completion pulse and read data
//   clr_start/clr_value       clear start pulse and fill byte
//   clr_busy/clr_done         clear in progress / one-cycle finish pulse
//   vram_addr/write/d_wr      VRAM macro controls (combinational grant mux)
//   vram_d_rd                 VRAM read data, valid the cycle after address
//
// Build option
//   VRAM_MODE3_LOCK_EN: when this macro is defined, CPU accesses made while
//   ppu_mode==3 do not reach VRAM. They still get acknowledged. Reads
//   return 8'hFF and writes are dropped. The default build ignores ppu_mode.
// ---------------------------------------------------------------------------
module vram_arb #(
  parameter int AW = 13,
  parameter int DW = 8
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [1:0]    ppu_mode,
  input  logic          ppu_req,
  input  logic [AW-1:0] ppu_addr,
  output logic          ppu_rd_valid,
  output logic [DW-1:0] ppu_rd_data,
  input  logic          cpu_req,
  input  logic          cpu_we,
  input  logic [AW-1:0] cpu_addr,
  input  logic [DW-1:0] cpu_wdata,
  output logic          cpu_ack,
  output logic [DW-1:0] cpu_rdata,
  input  logic          clr_start,
  input  logic [DW-1:0] clr_value,
  output logic          clr_busy,
  output logic          clr_done,
  output logic [AW-1:0] vram_addr,
  output logic          vram_write,
  output logic [DW-1:0] vram_d_wr,
  input  logic [DW-1:0] vram_d_rd
);

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_CPU_ACK = 2'd1,
    ST_CLEAR   = 2'd2
  } state_e;

  localparam logic [AW-1:0] LAST_ADDR = {AW{1'b1}};

  // CPU accesses are blocked from VRAM during pixel transfer only when the
  // lock option is built in.
  logic cpu_locked;
`ifdef VRAM_MODE3_LOCK_EN
  assign cpu_locked = (ppu_mode == 2'd3);
`else
  assign cpu_locked = 1'b0;
  logic unused_ppu_mode;
  assign unused_ppu_mode = ^ppu_mode;
`endif

  state_e        state_q, state_d;
  logic [AW-1:0] ptr_q, ptr_d;            // clear pointer
  logic [DW-1:0] fill_q, fill_d;          // latched clear value
  logic [AW-1:0] addr_q, addr_d;          // last address driven to VRAM
  logic [DW-1:0] wdata_q, wdata_d;        // last data driven to VRAM
  logic          cpu_rd_q, cpu_rd_d;      // access being acked was a read
  logic          cpu_lock_q, cpu_lock_d;  // access being acked was locked out
  logic          ppu_rd_valid_q, ppu_rd_valid_d;
  logic          clr_done_q, clr_done_d;

  // Grant and next-state logic. At most one requester owns VRAM per cycle.
  // While rst is high nothing is granted, so an aborted clear or CPU access
  // never issues another write.
  // NOTE: every signal assigned here gets a default first; a path that
  // leaves one unassigned would infer a latch.
  always_comb begin
    state_d        = state_q;
    ptr_d          = ptr_q;
    fill_d         = fill_q;
    addr_d         = addr_q;
    wdata_d        = wdata_q;
    cpu_rd_d       = cpu_rd_q;
    cpu_lock_d     = cpu_lock_q;
    ppu_rd_valid_d = 1'b0;
    clr_done_d     = 1'b0;
    vram_write     = 1'b0;

    if (!rst) begin
      // The PPU owns VRAM in any cycle where it strobes, whatever the state.
      if (ppu_req) begin
        addr_d         = ppu_addr;
        ppu_rd_valid_d = 1'b1;
      end

      unique case (state_q)
        ST_IDLE: begin
          // A clear start beats a waiting CPU request in the same cycle.
          if (clr_start) begin
            state_d = ST_CLEAR;
            ptr_d   = '0;
            fill_d  = clr_value;
          end else if (cpu_req && !ppu_req) begin
            state_d    = ST_CPU_ACK;
            cpu_rd_d   = !cpu_we;
            cpu_lock_d = cpu_locked;
            if (!cpu_locked) begin
              addr_d = cpu_addr;
              if (cpu_we) begin
                wdata_d    = cpu_wdata;
                vram_write = 1'b1;
              end
            end
          end
        end

        // The ack cycle does not sample cpu_req or clr_start. This keeps a
        // held request from being granted twice.
        ST_CPU_ACK: state_d = ST_IDLE;

        ST_CLEAR: begin
          // A PPU strobe steals the slot; the same pointer is retried.
          if (!ppu_req) begin
            addr_d     = ptr_q;
            wdata_d    = fill_q;
            vram_write = 1'b1;
            if (ptr_q == LAST_ADDR) begin
              state_d    = ST_IDLE;
              clr_done_d = 1'b1;
            end else begin
              ptr_d = ptr_q + 1'b1;
            end
          end
        end

        default: state_d = ST_IDLE;
      endcase
    end
  end

  // With no grant, the address and data lines hold their last value.
  assign vram_addr = addr_d;
  assign vram_d_wr = wdata_d;

  // NOTE: sequential state uses non-blocking assignments only, so every flop
  // samples the values from before the clock edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q        <= ST_IDLE;
      ptr_q          <= '0;
      fill_q         <= '0;
      addr_q         <= '0;
      wdata_q        <= '0;
      cpu_rd_q       <= 1'b0;
      cpu_lock_q     <= 1'b0;
      ppu_rd_valid_q <= 1'b0;
      clr_done_q     <= 1'b0;
    end else begin
      state_q        <= state_d;
      ptr_q          <= ptr_d;
      fill_q         <= fill_d;
      addr_q         <= addr_d;
      wdata_q        <= wdata_d;
      cpu_rd_q       <= cpu_rd_d;
      cpu_lock_q     <= cpu_lock_d;
      ppu_rd_valid_q <= ppu_rd_valid_d;
      clr_done_q     <= clr_done_d;
    end
  end

  // VRAM read data arrives one cycle after the grant, in the same cycle as
  // the valid/ack pulse, so the returns are steered from vram_d_rd directly.
  assign ppu_rd_valid = ppu_rd_valid_q;
  assign ppu_rd_data  = ppu_rd_valid_q ? vram_d_rd : '0;

  assign cpu_ack   = (state_q == ST_CPU_ACK);
  assign cpu_rdata = (cpu_ack && cpu_rd_q) ? (cpu_lock_q ? {DW{1'b1}} : vram_d_rd) : '0;

  assign clr_busy = (state_q == ST_CLEAR);
  assign clr_done = clr_done_q;

endmodule

// File: tb/tb_vram_arb.sv
// ---------------------------------------------------------------------------
// tb_vram_arb -- self-checking bench for vram_arb.
//
// The bench contains a behavioural VRAM macro. The DUT drives it, and it
// starts from a known pattern. A reference model in the bench tracks the
// expected memory contents and the clear/CPU bookkeeping. The model uses plain
// integers and arrays. Expected returns are queued with the cycle they are
// due in. A monitor compares the DUT outputs against the head of each queue
// in every cycle.
// ---------------------------------------------------------------------------
module tb_vram_arb;
  localparam int AW    = 13;
  localparam int DW    = 8;
  localparam int DEPTH = 1 << AW;

  logic          clk;
  logic          rst;
  logic [1:0]    ppu_mode;
  logic          ppu_req;
  logic [AW-1:0] ppu_addr;
  logic          ppu_rd_valid;
  logic [DW-1:0] ppu_rd_data;
  logic          cpu_req;
  logic          cpu_we;
  logic [AW-1:0] cpu_addr;
  logic [DW-1:0] cpu_wdata;
  logic          cpu_ack;
  logic [DW-1:0] cpu_rdata;
  logic          clr_start;
  logic [DW-1:0] clr_value;
  logic          clr_busy;
  logic          clr_done;
  logic [AW-1:0] vram_addr;
  logic          vram_write;
  logic [DW-1:0] vram_d_wr;
  logic [DW-1:0] vram_d_rd;

  vram_arb #(.AW(AW), .DW(DW)) dut (
    .clk         (clk),
    .rst         (rst),
    .ppu_mode    (ppu_mode),
    .ppu_req     (ppu_req),
    .ppu_addr    (ppu_addr),
    .ppu_rd_valid(ppu_rd_valid),
    .ppu_rd_data (ppu_rd_data),
    .cpu_req     (cpu_req),
    .cpu_we      (cpu_we),
    .cpu_addr    (cpu_addr),
    .cpu_wdata   (cpu_wdata),
    .cpu_ack     (cpu_ack),
    .cpu_rdata   (cpu_rdata),
    .clr_start   (clr_start),
    .clr_value   (clr_value),
    .clr_busy    (clr_busy),
    .clr_done    (clr_done),
    .vram_addr   (vram_addr),
    .vram_write  (vram_write),
    .vram_d_wr   (vram_d_wr),
    .vram_d_rd   (vram_d_rd)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // ---------------- checking bookkeeping ----------------
  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: actual=%0h expected=%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic logic [7:0] prefill(input int a);
    return 8'((a * 7) + (a >> 8)) ^ 8'h3C;
  endfunction

  // ---------------- VRAM macro (environment) ----------------
  logic [DW-1:0] vmem [DEPTH];
  bit            vmem_init = 1'b0;
  int            wr_count  = 0;

  always @(posedge clk) begin
    if (!vmem_init) begin
      for (int i = 0; i < DEPTH; i++) vmem[i] <= prefill(i);
      vmem_init <= 1'b1;
    end else if (vram_write) begin
      vmem[vram_addr] <= vram_d_wr;
      wr_count        <= wr_count + 1;
    end
    vram_d_rd <= vmem[vram_addr];
  end

  // ---------------- reference model ----------------
  typedef struct {
    int         due;
    logic [7:0] data;
    bit         is_rd;
  } exp_t;

  typedef struct {
    bit         we;
    logic [12:0] addr;
    logic [7:0] wdata;
  } cpu_txn_t;

  logic [7:0] ref_mem [DEPTH];
  exp_t       ppu_q[$];
  exp_t       cpu_q[$];
  int         done_q[$];
  cpu_txn_t   cpu_pend[$];
  int         cpu_phase  = 0;   // 0 none, 1 waiting for grant, 2 in ack cycle
  bit         m_busy     = 1'b0;
  int         m_ptr      = 0;
  logic [7:0] m_val      = '0;
  bit         m_in_ack   = 1'b0;
  int         m_preempt  = 0;
  int         exp_writes = 0;
  bit         exp_busy   = 1'b0;

  // Applies the rules for one clock cycle to the inputs that are being driven.
  task automatic model_step();
    bit         locked;
    logic [7:0] rd;
`ifdef VRAM_MODE3_LOCK_EN
    locked = (ppu_mode == 2'd3);
`else
    locked = 1'b0;
`endif
    if (rst) begin
      m_busy   = 1'b0;
      m_in_ack = 1'b0;
      if (cpu_phase == 1) begin
        cpu_req   = 1'b0;
        cpu_phase = 0;
      end
      exp_busy = 1'b0;
      return;
    end
    if (ppu_req) ppu_q.push_back('{due: cyc + 1, data: ref_mem[ppu_addr], is_rd: 1'b1});
    if (m_in_ack) begin
      m_in_ack = 1'b0;
    end else if (m_busy) begin
      if (ppu_req) begin
        m_preempt++;
      end else begin
        ref_mem[m_ptr] = m_val;
        exp_writes++;
        if (m_ptr == DEPTH - 1) begin
          m_busy = 1'b0;
          done_q.push_back(cyc + 1);
        end else begin
          m_ptr++;
        end
      end
    end else if (clr_start) begin
      m_busy = 1'b1;
      m_ptr  = 0;
      m_val  = clr_value;
    end else if (cpu_req && !ppu_req) begin
      rd = locked ? 8'hFF : ref_mem[cpu_addr];
      if (cpu_we && !locked) begin
        ref_mem[cpu_addr] = cpu_wdata;
        exp_writes++;
      end
      cpu_q.push_back('{due: cyc + 1, data: rd, is_rd: !cpu_we});
      m_in_ack  = 1'b1;
      cpu_phase = 2;
    end
    exp_busy = m_busy;
  endtask

  // Drives one clock cycle. The caller sets the inputs just after a negedge.
  task automatic tick();
    cpu_txn_t t;
    if (cpu_phase == 2) begin
      cpu_phase = 0;
      cpu_req   = 1'b0;
    end
    if (cpu_phase == 0 && cpu_pend.size() > 0 && !rst) begin
      t         = cpu_pend.pop_front();
      cpu_req   = 1'b1;
      cpu_we    = t.we;
      cpu_addr  = t.addr;
      cpu_wdata = t.wdata;
      cpu_phase = 1;
    end
    model_step();
    @(negedge clk);
    ppu_req   = 1'b0;
    clr_start = 1'b0;
  endtask

  task automatic cpu_push(input bit we, input logic [12:0] addr, input logic [7:0] wdata);
    cpu_pend.push_back('{we: we, addr: addr, wdata: wdata});
  endtask

  task automatic drain(input int max);
    int n = 0;
    while ((cpu_phase != 0 || cpu_pend.size() > 0 || m_busy) && n < max) begin
      tick();
      n++;
    end
    check("drain_bound", n < max, 1'b1);
    tick();
    tick();
  endtask

  // ---------------- monitor ----------------
  int busy_cnt  = 0;
  int done_seen = 0;

  always @(posedge clk) begin : monitor
    bit e;
    #1;
    e = (ppu_q.size() > 0) && (ppu_q[0].due == cyc);
    check("ppu_rd_valid", ppu_rd_valid, e);
    if (e) begin
      if (ppu_rd_valid) check("ppu_rd_data", ppu_rd_data, ppu_q[0].data);
      void'(ppu_q.pop_front());
    end
    e = (cpu_q.size() > 0) && (cpu_q[0].due == cyc);
    check("cpu_ack", cpu_ack, e);
    if (e) begin
      if (cpu_ack && cpu_q[0].is_rd) check("cpu_rdata", cpu_rdata, cpu_q[0].data);
      void'(cpu_q.pop_front());
    end
    e = (done_q.size() > 0) && (done_q[0] == cyc);
    check("clr_done", clr_done, e);
    if (e) void'(done_q.pop_front());
    check("clr_busy", clr_busy, exp_busy);
    if (clr_busy) busy_cnt <= busy_cnt + 1;
    if (clr_done) done_seen <= done_seen + 1;
  end

  // ---------------- watchdog ----------------
  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  // ---------------- stimulus ----------------
  initial begin
    int b0, d0, p0, w0, mism, i;
    rst       = 1'b1;
    ppu_mode  = 2'd0;
    ppu_req   = 1'b0;
    ppu_addr  = '0;
    cpu_req   = 1'b0;
    cpu_we    = 1'b0;
    cpu_addr  = '0;
    cpu_wdata = '0;
    clr_start = 1'b0;
    clr_value = '0;
    for (int k = 0; k < DEPTH; k++) ref_mem[k] = prefill(k);

    // Reset state
    repeat (3) tick();
    check("rst_vram_addr",    vram_addr,    '0);
    check("rst_vram_write",   vram_write,   '0);
    check("rst_vram_d_wr",    vram_d_wr,    '0);
    check("rst_cpu_ack",      cpu_ack,      '0);
    check("rst_cpu_rdata",    cpu_rdata,    '0);
    check("rst_clr_busy",     clr_busy,     '0);
    check("rst_clr_done",     clr_done,     '0);
    check("rst_ppu_rd_valid", ppu_rd_valid, '0);
    rst = 1'b0;
    tick();

    // Basic CPU write then read-back
    cpu_push(1'b1, 13'h1234, 8'hA5);
    cpu_push(1'b0, 13'h1234, 8'h00);
    drain(100);

    // A PPU strobe collides with a fresh CPU read
    ppu_req  = 1'b1;
    ppu_addr = 13'h0010;
    cpu_push(1'b0, 13'h0020, 8'h00);
    tick();
    drain(100);

    // Uncontested clear to 0x00
    b0 = busy_cnt;
    d0 = done_seen;
    clr_start = 1'b1;
    clr_value = 8'h00;
    tick();
    drain(9000);
    check("clear_busy_cycles", busy_cnt - b0, 8192);
    check("clear_done_pulses", done_seen - d0, 1);
    cpu_push(1'b0, 13'h0000, 8'h00);
    cpu_push(1'b0, 13'h1000, 8'h00);
    cpu_push(1'b0, 13'h1FFF, 8'h00);
    drain(100);

    // Clear with a PPU strobe every 4th cycle
    b0 = busy_cnt;
    p0 = m_preempt;
    clr_start = 1'b1;
    clr_value = 8'h96;
    tick();
    i = 0;
    while (m_busy && i < 12000) begin
      ppu_req  = (i % 4 == 0);
      ppu_addr = AW'($urandom);
      tick();
      i++;
    end
    drain(100);
    check("clear_ppu_busy_cycles", busy_cnt - b0, 8192 + (m_preempt - p0));
    cpu_push(1'b0, 13'h0003, 8'h00);
    cpu_push(1'b0, 13'h1FFC, 8'h00);
    drain(100);

`ifdef VRAM_MODE3_LOCK_EN
    // CPU locked out during pixel transfer
    ppu_mode = 2'd3;
    cpu_push(1'b1, 13'h0100, 8'h5A);
    cpu_push(1'b0, 13'h0100, 8'h00);
    drain(100);
    ppu_mode = 2'd0;
    cpu_push(1'b0, 13'h0100, 8'h00);
    drain(100);
`endif

    // Reset part-way through a clear, then restart the clear
    d0 = done_seen;
    clr_start = 1'b1;
    clr_value = 8'hC3;
    tick();
    repeat (12'h800) tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("clr_busy_after_rst", clr_busy, 1'b0);
    w0 = wr_count;
    repeat (20) tick();
    check("no_writes_after_rst", wr_count - w0, 0);
    check("no_done_after_rst", done_seen - d0, 0);
    cpu_push(1'b0, 13'h0005, 8'h00);
    cpu_push(1'b0, 13'h0900, 8'h00);
    drain(100);
    b0 = busy_cnt;
    clr_start = 1'b1;
    clr_value = 8'h3C;
    tick();
    drain(9000);
    check("restart_busy_cycles", busy_cnt - b0, 8192);
    cpu_push(1'b0, 13'h0000, 8'h00);
    drain(100);

    // Random mixed traffic
    for (int n = 0; n < 3000; n++) begin
      ppu_req  = ($urandom_range(0, 3) == 0);
      ppu_addr = AW'($urandom_range(0, 63));
      ppu_mode = 2'($urandom_range(0, 3));
      if (cpu_pend.size() < 2 && $urandom_range(0, 2) == 0)
        cpu_push(1'($urandom), AW'($urandom_range(0, 63)), 8'($urandom));
      clr_start = ($urandom_range(0, 999) == 0);
      clr_value = 8'($urandom);
      tick();
    end
    drain(20000);

    // Final accounting
    check("write_count", wr_count, exp_writes);
    mism = 0;
    for (int k = 0; k < DEPTH; k++) if (vmem[k] !== ref_mem[k]) mism++;
    check("vram_contents", mism, 0);
    check("ppu_q_empty", ppu_q.size(), 0);
    check("cpu_q_empty", cpu_q.size(), 0);
    check("done_q_empty", done_q.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
